// File: rtl/packet_resizer_ts_if.sv
// AXI-Stream bundle carrying a sample stream with its 128-bit CHDR header.
//   tdata  : WIDTH-bit payload beat
//   tuser  : CHDR header {TYPE[127:126], TSI, EOB, SEQ[123:112], LEN[111:96],
//            SRC[95:80], DST[79:64], TIME[63:0]}
//   tlast  : end of packet
//   tvalid : source has a beat
//   tready : sink can take a beat
// Handshake: a beat transfers on a clock edge where tvalid & tready are both
// high; once tvalid is raised the source holds the beat stable until it has
// transferred, and tready may depend combinationally on the sink's state.
interface packet_resizer_ts_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic [127:0]     tuser;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/packet_resizer_ts.sv
// packet_resizer_ts: re-frames a CHDR sample stream into output packets of a
// programmable byte size, with one registered output stage.  Each output
// packet gets a header latched on its first beat with a regenerated
// timestamp and, optionally, a regenerated sequence number.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   clear             : synchronous state clear (setting registers kept)
//   next_dst_sid      : DST SID written into every output header
//   set_stb/addr/data : settings bus (SR_PKT_SIZE = bytes, SR_CTRL = {SEQ_REGEN, TIME_ALL})
//   i_axis            : input stream (slave)
//   o_axis            : output stream (master)
module packet_resizer_ts #(
  parameter int          WIDTH       = 32,
  parameter logic [7:0]  SR_PKT_SIZE = 8'd1,
  parameter logic [7:0]  SR_CTRL     = 8'd2,
  parameter logic [15:0] TIME_STEP   = 16'd1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [15:0]                next_dst_sid,
  input  logic                       set_stb,
  input  logic [7:0]                 set_addr,
  input  logic [31:0]                set_data,
  packet_resizer_ts_if.slave         i_axis,
  packet_resizer_ts_if.master        o_axis
);

  localparam int          BPB   = WIDTH / 8;
  localparam logic [16:0] BPB_C = 17'(BPB);

  typedef struct packed {
    logic [1:0]  ptype;
    logic        tsi;
    logic [11:0] seq;
    logic [15:0] len;
    logic [15:0] src;
    logic [15:0] dst;
    logic [63:0] ts;
  } hdr_t;

  // Setting registers (survive clear)
  logic [15:0] pkt_size_q;
  logic [1:0]  ctrl_q;

  // Framing state; cnt/size are 17 bits so cnt + BPB never wraps
  logic             first_out_q, first_out_d;
  logic             first_in_q, first_in_d;
  logic             fib_q, fib_d;
  logic [16:0]      cnt_q, cnt_d;
  logic [16:0]      size_l_q, size_l_d;
  logic [63:0]      time_acc_q, time_acc_d;
  logic [11:0]      seq_cnt_q, seq_cnt_d;
  hdr_t             hdr_q, hdr_d;

  // Output register stage
  logic             o_tvalid_q, o_tvalid_d;
  logic             o_tlast_q, o_tlast_d;
  logic [WIDTH-1:0] o_tdata_q, o_tdata_d;
  logic [127:0]     o_tuser_q, o_tuser_d;

  // Per-beat combinational terms
  logic        in_ready, accept;
  logic [16:0] size_eff, size_cur, cnt_cur;
  logic        eob_beat, beat_last;
  logic [63:0] cur_time;
  hdr_t        hdr_new, hdr_cur;

  // The incoming SRC field is replaced by the incoming DST, and only the low
  // 16 setting bits are meaningful.
  logic unused_bits;
  assign unused_bits = ^{set_data[31:16], i_axis.tuser[95:80]};

  always_comb begin
    in_ready = ~o_tvalid_q | o_axis.tready;
    accept   = i_axis.tvalid & in_ready;

    size_eff = ({1'b0, pkt_size_q} < BPB_C) ? BPB_C : {1'b0, pkt_size_q};
    // A first beat uses the live size; later beats use the latched one, so a
    // mid-packet size write only affects the next packet.
    size_cur = first_out_q ? size_eff : size_l_q;
    cnt_cur  = first_out_q ? BPB_C : (cnt_q + BPB_C);

    eob_beat  = i_axis.tuser[124] & i_axis.tlast;
    beat_last = (cnt_cur >= size_cur) | eob_beat;

    cur_time = (first_in_q & i_axis.tuser[125]) ? i_axis.tuser[63:0] : time_acc_q;

    hdr_new.ptype = i_axis.tuser[127:126];
    hdr_new.tsi   = i_axis.tuser[125] & (fib_q | ctrl_q[0]);
    hdr_new.seq   = ctrl_q[1] ? seq_cnt_q : i_axis.tuser[123:112];
    hdr_new.len   = i_axis.tuser[111:96];
    hdr_new.src   = i_axis.tuser[79:64];
    hdr_new.dst   = next_dst_sid;
    hdr_new.ts    = cur_time;
    hdr_cur       = first_out_q ? hdr_new : hdr_q;

    first_out_d = first_out_q;
    first_in_d  = first_in_q;
    fib_d       = fib_q;
    cnt_d       = cnt_q;
    size_l_d    = size_l_q;
    time_acc_d  = time_acc_q;
    seq_cnt_d   = seq_cnt_q;
    hdr_d       = hdr_q;
    o_tvalid_d  = o_tvalid_q & ~o_axis.tready;
    o_tlast_d   = o_tlast_q;
    o_tdata_d   = o_tdata_q;
    o_tuser_d   = o_tuser_q;

    if (accept) begin
      o_tvalid_d  = 1'b1;
      o_tlast_d   = beat_last;
      o_tdata_d   = i_axis.tdata;
      o_tuser_d   = {hdr_cur.ptype, hdr_cur.tsi, eob_beat, hdr_cur.seq, hdr_cur.len,
                     hdr_cur.src, hdr_cur.dst, hdr_cur.ts};
      hdr_d       = hdr_cur;
      cnt_d       = cnt_cur;
      size_l_d    = size_cur;
      time_acc_d  = cur_time + {48'd0, TIME_STEP};
      first_out_d = beat_last;
      first_in_d  = i_axis.tlast;
      if (beat_last) begin
        seq_cnt_d = seq_cnt_q + 12'd1;
        fib_d     = eob_beat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_size_q <= 16'(BPB);
      ctrl_q     <= 2'd0;
    end else if (set_stb) begin
      if (set_addr == SR_PKT_SIZE) pkt_size_q <= set_data[15:0];
      if (set_addr == SR_CTRL)     ctrl_q     <= set_data[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      first_out_q <= 1'b1;
      first_in_q  <= 1'b1;
      fib_q       <= 1'b1;
      cnt_q       <= '0;
      size_l_q    <= '0;
      time_acc_q  <= '0;
      seq_cnt_q   <= '0;
      hdr_q       <= '0;
      o_tvalid_q  <= 1'b0;
      o_tlast_q   <= 1'b0;
      o_tdata_q   <= '0;
      o_tuser_q   <= '0;
    end else begin
      first_out_q <= first_out_d;
      first_in_q  <= first_in_d;
      fib_q       <= fib_d;
      cnt_q       <= cnt_d;
      size_l_q    <= size_l_d;
      time_acc_q  <= time_acc_d;
      seq_cnt_q   <= seq_cnt_d;
      hdr_q       <= hdr_d;
      o_tvalid_q  <= o_tvalid_d;
      o_tlast_q   <= o_tlast_d;
      o_tdata_q   <= o_tdata_d;
      o_tuser_q   <= o_tuser_d;
    end
  end

  assign i_axis.tready = in_ready;
  assign o_axis.tvalid = o_tvalid_q;
  assign o_axis.tlast  = o_tlast_q;
  assign o_axis.tdata  = o_tdata_q;
  assign o_axis.tuser  = o_tuser_q;

endmodule
